// File: rtl/systolic_skew_buffer.sv
// Stallable per-lane skew/deskew delay buffer for the systolic array edges.
// Lane i is delayed by a lane-dependent number of advances and carries valid and frame-end tags.
module systolic_skew_buffer #(
  parameter int LANES      = 8,
  parameter int WORDWIDTH  = 8,
  parameter int BASE_DELAY = 1,
  parameter int DIR        = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [LANES*WORDWIDTH-1:0] in_data,
  input  logic                       out_ready,
  output logic [LANES-1:0]           out_valid,
  output logic                       out_last,
  output logic [LANES*WORDWIDTH-1:0] out_data
);

  localparam int MAXD = BASE_DELAY + LANES - 1;
  localparam int CW   = $clog2(MAXD) + 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(MAXD - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic {
    STREAM = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              drain_cnt_q, drain_cnt_d;
  logic [MAXD-1:0]            last_q, last_d;
  logic                       advance;
  logic                       accept;
  logic                       load_last;
  logic [LANES*WORDWIDTH-1:0] load_data;

  assign advance   = out_ready && !clear;
  assign in_ready  = advance && (state_q == STREAM);
  assign accept    = in_valid && in_ready;
  assign load_last = accept && in_last;
  assign load_data = accept ? in_data : '0;

  // While draining only bubbles enter, so the tagged word can flush to the longest lane's output.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (clear) begin
      state_d     = STREAM;
      drain_cnt_d = '0;
    end else if (advance) begin
      if (state_q == STREAM) begin
        if (load_last && (MAXD > 1)) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end else begin
        drain_cnt_d = drain_cnt_q - CNT_ONE;
        if (drain_cnt_q == CNT_ONE) begin
          state_d = STREAM;
        end
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (clear) begin
      last_d = '0;
    end else if (advance) begin
      last_d[0] = load_last;
      for (int s = 1; s < MAXD; s++) begin
        last_d[s] = last_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= STREAM;
      drain_cnt_q <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      last_q      <= last_d;
    end
  end

  assign out_last = last_q[MAXD-1];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int D = (DIR != 0) ? (BASE_DELAY + LANES - 1 - i) : (BASE_DELAY + i);

    logic [D-1:0]         valid_q, valid_d;
    logic [WORDWIDTH-1:0] data_q [D];
    logic [WORDWIDTH-1:0] data_d [D];

    always_comb begin
      valid_d = valid_q;
      for (int s = 0; s < D; s++) begin
        data_d[s] = data_q[s];
      end
      if (clear) begin
        valid_d = '0;
        for (int s = 0; s < D; s++) begin
          data_d[s] = '0;
        end
      end else if (advance) begin
        valid_d[0] = accept;
        data_d[0]  = load_data[i*WORDWIDTH +: WORDWIDTH];
        for (int s = 1; s < D; s++) begin
          valid_d[s] = valid_q[s-1];
          data_d[s]  = data_q[s-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= '0;
        for (int s = 0; s < D; s++) begin
          data_q[s] <= '0;
        end
      end else begin
        valid_q <= valid_d;
        for (int s = 0; s < D; s++) begin
          data_q[s] <= data_d[s];
        end
      end
    end

    assign out_valid[i]                          = valid_q[D-1];
    assign out_data[i*WORDWIDTH +: WORDWIDTH]    = data_q[D-1];
  end

endmodule
